// File: rtl/lift_pkg.sv
// Shared floor codes, one-hot floor constants, FSM and direction encodings
// used by the lift call scheduler and the floor controller.
package lift_pkg;

    localparam logic [1:0] FIRST  = 2'b00;
    localparam logic [1:0] SECOND = 2'b01;
    localparam logic [1:0] THIRD  = 2'b11;

    localparam logic [2:0] OH_FIRST  = 3'b001;
    localparam logic [2:0] OH_SECOND = 3'b010;
    localparam logic [2:0] OH_THIRD  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEEK   = 2'b01,
        ST_ARRIVE = 2'b10
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic is_onehot(input logic [2:0] oh);
        return (oh == OH_FIRST) || (oh == OH_SECOND) || (oh == OH_THIRD);
    endfunction

    function automatic logic [2:0] code_to_onehot(input logic [1:0] code);
        case (code)
            FIRST:   return OH_FIRST;
            SECOND:  return OH_SECOND;
            THIRD:   return OH_THIRD;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_code(input logic [2:0] oh);
        case (oh)
            OH_SECOND: return SECOND;
            OH_THIRD:  return THIRD;
            default:   return FIRST;
        endcase
    endfunction

    // Returns {hit, code} of the nearest pending call strictly beyond the
    // current floor in the given direction.
    function automatic logic [2:0] nearest_call(input logic [2:0] calls,
                                                input logic [2:0] floor_oh,
                                                input dir_e       dir);
        logic [2:0] r;
        r = {1'b0, FIRST};
        if (dir == DIR_UP) begin
            case (floor_oh)
                OH_FIRST:  r = calls[1] ? {1'b1, SECOND} :
                               (calls[2] ? {1'b1, THIRD} : {1'b0, FIRST});
                OH_SECOND: r = calls[2] ? {1'b1, THIRD} : {1'b0, FIRST};
                default:   r = {1'b0, FIRST};
            endcase
        end else begin
            case (floor_oh)
                OH_THIRD:  r = calls[1] ? {1'b1, SECOND} :
                               (calls[0] ? {1'b1, FIRST} : {1'b0, FIRST});
                OH_SECOND: r = calls[0] ? {1'b1, FIRST} : {1'b0, FIRST};
                default:   r = {1'b0, FIRST};
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] step_code(input logic [2:0] floor_oh,
                                             input logic [1:0] tgt);
        case ({floor_oh, tgt})
            {OH_FIRST,  THIRD}:  return 2'b01;
            {OH_SECOND, THIRD}:  return 2'b01;
            {OH_THIRD,  SECOND}: return 2'b11;
            default:             return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lift_call_latch.sv
// Call button latch: one sync stage, rising-edge detect, and per-floor
// pending-call register with set-over-clear priority.
module lift_call_latch
    import lift_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic [2:0] clr,
    input  logic [2:0] drop,
    output logic [2:0] call_lamp
);

    logic [2:0] btn_sync_q;
    logic [2:0] btn_q;
    logic [2:0] lamp_q;
    logic [2:0] lamp_d;
    logic [2:0] rise_s;

    assign rise_s = btn_sync_q & ~btn_q;
    assign lamp_d = (lamp_q & ~clr) | (rise_s & ~drop);

    // Button sampling and pending-call register
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync_q <= 3'b000;
            btn_q      <= 3'b000;
            lamp_q     <= 3'b000;
        end else begin
            btn_sync_q <= btn;
            btn_q      <= btn_sync_q;
            lamp_q     <= lamp_d;
        end
    end

    assign call_lamp = lamp_q;

endmodule

// File: rtl/lift_call_scheduler.sv
// Lift call scheduler: picks a target from pending calls, steers the floor
// controller, clears calls on arrival and holds the doors for DWELL cycles.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic [2:0] floor,
    output logic [1:0] step,
    output logic       step_valid,
    output logic [1:0] target,
    output logic [2:0] call_lamp,
    output logic       door_open,
    output logic       busy,
    output logic       fault
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    state_e       state_q, state_d;
    dir_e         dir_q, dir_d, dir_rev_s;
    logic [1:0]   target_q, target_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]   step_q, step_d;
    logic         step_valid_q, door_open_q, busy_q, fault_q;
    logic [2:0]   clr_s, drop_s, calls_s;
    logic [2:0]   near_fwd_s, near_rev_s;
    logic         floor_ok_s;

    lift_call_latch u_latch (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .clr       (clr_s),
        .drop      (drop_s),
        .call_lamp (calls_s)
    );

    assign floor_ok_s = is_onehot(floor);
    assign dir_rev_s  = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
    assign near_fwd_s = nearest_call(calls_s, floor, dir_q);
    assign near_rev_s = nearest_call(calls_s, floor, dir_rev_s);

    // Next-state, call clear/drop and dwell counter control
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        clr_s    = 3'b000;
        drop_s   = 3'b000;
        step_d   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (!floor_ok_s || (calls_s == 3'b000)) begin
                    state_d = ST_IDLE;
                end else if ((calls_s & floor) != 3'b000) begin
                    clr_s    = floor;
                    target_d = onehot_to_code(floor);
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_ARRIVE;
                end else if (near_fwd_s[2]) begin
                    target_d = near_fwd_s[1:0];
                    state_d  = ST_SEEK;
                end else begin
                    dir_d    = dir_rev_s;
                    target_d = near_rev_s[1:0];
                    state_d  = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (floor == code_to_onehot(target_q)) begin
                    clr_s   = floor;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ARRIVE;
                end else begin
                    state_d = ST_SEEK;
                end
            end
            ST_ARRIVE: begin
                // A fresh press for the floor being serviced is discarded.
                drop_s = code_to_onehot(target_q);
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_SEEK) begin
            step_d = floor_ok_s ? step_code(floor, target_d) : step_q;
        end else begin
            step_d = 2'b00;
        end
    end

    // State, direction, target, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_UP;
            target_q     <= FIRST;
            cnt_q        <= {CW{1'b0}};
            step_q       <= 2'b00;
            step_valid_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            step_valid_q <= (state_d == ST_SEEK);
            door_open_q  <= (state_d == ST_ARRIVE);
            busy_q       <= (state_d != ST_IDLE);
            fault_q      <= fault_q | ~floor_ok_s;
        end
    end

    assign step       = step_q;
    assign step_valid = step_valid_q;
    assign target     = target_q;
    assign call_lamp  = calls_s;
    assign door_open  = door_open_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule
